// File: rtl/efuse_ctrl_pkg.sv
// Shared types and constants for the eFuse load controller and its APB front end.
package efuse_ctrl_pkg;

  // Load sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } efuse_state_e;

  // Register byte addresses
  localparam int unsigned REG_CTRL     = 32'h00;
  localparam int unsigned REG_STATUS   = 32'h01;
  localparam int unsigned REG_STRB_CFG = 32'h02;
  localparam int unsigned SHADOW_BASE  = 32'h80;

  // Shortest legal strobe width; a programmed 0 is promoted to this
  localparam int unsigned STRB_MIN = 1;

  function automatic logic [3:0] strb_sanitize(input logic [3:0] v);
    return (v == 4'd0) ? 4'(STRB_MIN) : v;
  endfunction

endpackage

// File: rtl/efuse_apb_regs.sv
// APB slave front end: address decode, strobe-width register, error response
// and the shadow byte read mux. Zero wait states; read data is combinational.
module efuse_apb_regs
  import efuse_ctrl_pkg::*;
#(
  parameter int EFUSE_BIT = 1024,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int STRB_DEF  = 4
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [AW-1:0]        paddr_i,
  input  logic [DW-1:0]        pwdata_i,
  input  logic                 busy_i,
  input  logic                 load_done_i,
  input  logic [EFUSE_BIT-1:0] shadow_i,
  output logic [DW-1:0]        prdata_o,
  output logic                 pslverr_o,
  output logic                 start_o,
  output logic [3:0]           strb_cfg_o
);

  localparam int NBYTES = EFUSE_BIT / 8;
  localparam logic [AW-1:0] A_CTRL   = AW'(REG_CTRL);
  localparam logic [AW-1:0] A_STATUS = AW'(REG_STATUS);
  localparam logic [AW-1:0] A_STRB   = AW'(REG_STRB_CFG);
  localparam logic [AW-1:0] A_SHADOW = AW'(SHADOW_BASE);

  logic          access;
  logic          hit_shadow;
  logic [AW-1:0] sh_off;
  logic [7:0]    sh_byte;
  logic [3:0]    strb_q, strb_d;
  logic          unused_pwdata;

  assign access        = psel_i & penable_i;
  assign sh_off        = paddr_i - A_SHADOW;
  assign hit_shadow    = (paddr_i >= A_SHADOW) && (sh_off < AW'(NBYTES));
  assign strb_cfg_o    = strb_q;
  assign unused_pwdata = ^pwdata_i[DW-1:4];

  // Select the addressed shadow byte; bit k of byte n is fuse bit 8n+k
  always_comb begin
    sh_byte = '0;
    for (int n = 0; n < NBYTES; n++) begin
      if (sh_off == AW'(n)) sh_byte = shadow_i[8*n +: 8];
    end
  end

  // Decode the access phase into read data, error, start pulse and STRB_CFG update
  always_comb begin
    prdata_o  = '0;
    pslverr_o = 1'b0;
    start_o   = 1'b0;
    strb_d    = strb_q;
    if (access) begin
      if (paddr_i == A_CTRL) begin
        // START is only honoured when idle; otherwise silently ignored
        if (pwrite_i) start_o = pwdata_i[0] & ~busy_i;
      end else if (paddr_i == A_STATUS) begin
        if (pwrite_i) pslverr_o = 1'b1;
        else          prdata_o  = DW'({load_done_i, busy_i});
      end else if (paddr_i == A_STRB) begin
        if (pwrite_i) begin
          // Changing the strobe width under a running load is refused
          if (busy_i) pslverr_o = 1'b1;
          else        strb_d    = strb_sanitize(pwdata_i[3:0]);
        end else begin
          prdata_o = DW'(strb_q);
        end
      end else if (hit_shadow) begin
        if (pwrite_i) begin
          pslverr_o = 1'b1;
        end else begin
          // Partial contents are still returned, flagged as not yet valid
          prdata_o  = DW'(sh_byte);
          pslverr_o = busy_i;
        end
      end else begin
        pslverr_o = 1'b1;
      end
    end
  end

  // Strobe-width configuration register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) strb_q <= 4'(STRB_DEF);
    else         strb_q <= strb_d;
  end

endmodule

// File: rtl/efuse_load_ctrl.sv
// eFuse load controller: reads the fuse macro one bit at a time into a shadow
// register file and exposes it over APB. load_done qualifies the shadow as valid.
module efuse_load_ctrl
  import efuse_ctrl_pkg::*;
#(
  parameter  int EFUSE_BIT      = 1024,
  parameter  int APB_ADDR_WIDTH = 8,
  parameter  int APB_DATA_WIDTH = 8,
  parameter  int STRB_DEF       = 4,
  parameter  int AUTO_LOAD      = 1,
  localparam int EA_W           = $clog2(EFUSE_BIT)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic [APB_DATA_WIDTH-1:0] prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      efuse_csb,
  output logic [EA_W-1:0]           efuse_addr,
  output logic                      efuse_strobe,
  input  logic                      efuse_dout,
  output logic                      busy,
  output logic                      load_done
);

  efuse_state_e         state_q, state_d;
  logic [EA_W-1:0]      addr_q, addr_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           slen_q, slen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 auto_q;
  logic                 dout_q;
  logic [EFUSE_BIT-1:0] shadow_q, shadow_d;
  logic                 start_req;
  logic [3:0]           strb_cfg;

  efuse_apb_regs #(
    .EFUSE_BIT (EFUSE_BIT),
    .AW        (APB_ADDR_WIDTH),
    .DW        (APB_DATA_WIDTH),
    .STRB_DEF  (STRB_DEF)
  ) u_regs (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .psel_i      (psel),
    .penable_i   (penable),
    .pwrite_i    (pwrite),
    .paddr_i     (paddr),
    .pwdata_i    (pwdata),
    .busy_i      (busy_q),
    .load_done_i (done_q),
    .shadow_i    (shadow_q),
    .prdata_o    (prdata),
    .pslverr_o   (pslverr),
    .start_o     (start_req),
    .strb_cfg_o  (strb_cfg)
  );

  assign pready       = 1'b1;
  assign efuse_csb    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign efuse_strobe = (state_q == ST_STROBE);
  assign efuse_addr   = addr_q;
  assign busy         = busy_q;
  assign load_done    = done_q;

  // Next-state logic for the bit-serial load sequence and shadow updates
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    slen_d   = slen_q;
    busy_d   = busy_q;
    done_d   = done_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (start_req || auto_q) begin
          shadow_d = '0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          addr_d   = '0;
          // Strobe width is frozen for the whole load
          slen_d   = strb_cfg;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        cnt_d   = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (cnt_q == slen_q - 4'd1) state_d = ST_CAPTURE;
        else                        cnt_d   = cnt_q + 4'd1;
      end
      ST_CAPTURE: begin
        shadow_d[addr_q] = dout_q;
        if (addr_q == EA_W'(EFUSE_BIT - 1)) begin
          // Address is left parked on the last bit until the next start
          state_d = ST_DONE;
        end else begin
          addr_d  = addr_q + EA_W'(1);
          state_d = ST_SETUP;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer, counters and shadow register file
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      slen_q   <= 4'(STRB_DEF);
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      slen_q   <= slen_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
    end
  end

  // One-shot auto-load request, live only in the first cycle after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) auto_q <= (AUTO_LOAD != 0);
    else       auto_q <= 1'b0;
  end

  // Macro data sampled while strobing; the last strobe cycle's value is captured
  always_ff @(posedge clk) begin
    if (state_q == ST_STROBE) dout_q <= efuse_dout;
  end

endmodule

// File: tb/tb_efuse_load_ctrl.sv
// Self-checking bench for efuse_load_ctrl with a behavioural fuse macro and
// expected shadow/latency derived from the fuse contents and strobe width.
module tb_efuse_load_ctrl;

  localparam int N  = 1024;
  localparam int NB = N / 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr, efuse_csb, efuse_strobe, efuse_dout, busy, load_done;
  logic [9:0] efuse_addr;

  logic [N-1:0] fuse_mem;

  int         checks, errors, cyc, strb_cycles, csb_err, addr_err;
  logic [9:0] last_addr;

  efuse_load_ctrl dut (
    .clk          (clk),
    .rstn         (rstn),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .paddr        (paddr),
    .pwdata       (pwdata),
    .prdata       (prdata),
    .pready       (pready),
    .pslverr      (pslverr),
    .efuse_csb    (efuse_csb),
    .efuse_addr   (efuse_addr),
    .efuse_strobe (efuse_strobe),
    .efuse_dout   (efuse_dout),
    .busy         (busy),
    .load_done    (load_done)
  );

  always #5 clk = ~clk;

  // Fuse macro: true data while strobed, inverted data otherwise
  assign efuse_dout = efuse_strobe ? fuse_mem[efuse_addr] : ~fuse_mem[efuse_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (efuse_strobe) strb_cycles++;
    if (efuse_strobe && efuse_csb) csb_err++;
    if (efuse_addr != last_addr) begin
      if (efuse_addr != 10'(last_addr + 1) && efuse_addr != 10'd0) addr_err++;
      last_addr = efuse_addr;
    end
  endtask

  task automatic clr_stats();
    strb_cycles = 0;
    csb_err     = 0;
    addr_err    = 0;
    last_addr   = efuse_addr;
  endtask

  task automatic apb_write(input logic [7:0] a, input logic [7:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    #1 err = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [7:0] d, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    tick();
    penable = 1'b1;
    #1;
    d   = prdata;
    err = pslverr;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int budget, output int lat);
    while (load_done !== 1'b1 && (cyc - c0) < budget) tick();
    lat = cyc - c0;
  endtask

  task automatic wait_addr(input int a, input int c0, input int budget);
    while (int'(efuse_addr) < a && (cyc - c0) < budget) tick();
  endtask

  task automatic rand_fuse();
    for (int i = 0; i < N / 32; i++) fuse_mem[32*i +: 32] = $urandom;
  endtask

  task automatic check_shadow(input string tag);
    logic [7:0] d;
    logic       e;
    logic [7:0] exp_b;
    for (int n = 0; n < NB; n++) begin
      exp_b = fuse_mem[8*n +: 8];
      apb_read(8'(8'h80 + n), d, e);
      chk($sformatf("%s_shadow[%0d]", tag, n), {23'd0, e, d}, {23'd0, 1'b0, exp_b});
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       e;
    logic [7:0] acc;
    int         c0, lat;

    checks = 0; errors = 0; cyc = 0;
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    for (int n = 0; n < NB; n++) fuse_mem[8*n +: 8] = 8'(n) ^ 8'hA5;
    clr_stats();
    last_addr = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_outs", {efuse_csb, efuse_strobe, busy, load_done, pslverr, pready}, 6'b100001);
    chk("rst_addr", efuse_addr, 0);
    chk("rst_prdata", prdata, 0);

    // Auto-load with default strobe width
    clr_stats();
    rstn = 1'b1;
    tick();
    c0 = cyc;
    wait_done(c0, 7000, lat);
    chk("auto_latency", lat, N * (4 + 2) + 1);
    chk("auto_strobe_cycles", strb_cycles, N * 4);
    chk("auto_csb", csb_err, 0);
    chk("auto_addr_seq", addr_err, 0);
    chk("auto_addr_hold", efuse_addr, N - 1);
    apb_read(8'h80, d, e);
    chk("auto_sh00", {e, d}, {1'b0, 8'hA5});
    apb_read(8'hFF, d, e);
    chk("auto_sh7f", {e, d}, {1'b0, 8'hDA});
    check_shadow("auto");

    // STRB_CFG=0 is stored as 1; START lands on the DONE cycle and is ignored
    apb_write(8'h02, 8'h00, e);
    chk("strb0_wr_err", e, 0);
    apb_read(8'h02, d, e);
    chk("strb0_rd", {e, d}, {1'b0, 8'h01});
    rand_fuse();
    clr_stats();
    apb_write(8'h00, 8'h01, e);
    c0 = cyc;
    chk("s1_start_err", e, 0);
    chk("s1_done_drop", load_done, 0);
    while (!(efuse_strobe && efuse_addr == 10'(N - 1)) && (cyc - c0) < 4000) tick();
    tick();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 8'h01;
    tick();
    penable = 1'b1;
    #1 chk("s1_start_at_done_err", pslverr, 0);
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    lat = cyc - c0;
    chk("s1_latency", lat, N * (1 + 2) + 1);
    chk("s1_status_end", {busy, load_done}, 2'b01);
    tick();
    chk("s1_no_restart", {busy, load_done}, 2'b01);
    chk("s1_strobe_cycles", strb_cycles, N * 1);
    chk("s1_addr_seq", addr_err, 0);
    check_shadow("s1");

    // Mid-load accesses: refused STRB write, flagged shadow read, ignored START
    apb_write(8'h02, 8'h04, e);
    chk("strb4_wr_err", e, 0);
    rand_fuse();
    clr_stats();
    apb_write(8'h00, 8'h01, e);
    c0 = cyc;
    wait_addr(200, c0, 5000);
    apb_write(8'h02, 8'h09, e);
    chk("busy_strb_wr_err", e, 1);
    apb_read(8'h02, d, e);
    chk("busy_strb_rd", {e, d}, {1'b0, 8'h04});
    apb_read(8'h90, d, e);
    chk("busy_sh10_rd", {e, d}, {1'b1, fuse_mem[8*16 +: 8]});
    apb_read(8'h01, d, e);
    chk("busy_status", {e, d}, {1'b0, 8'h01});
    wait_addr(300, c0, 5000);
    apb_write(8'h00, 8'h01, e);
    chk("busy_start_err", e, 0);
    chk("busy_start_no_restart", int'(efuse_addr) >= 300, 1);
    wait_done(c0, 7000, lat);
    chk("mid_latency", lat, N * (4 + 2) + 1);
    chk("mid_strobe_cycles", strb_cycles, N * 4);
    chk("mid_addr_seq", addr_err, 0);
    check_shadow("mid");

    // Error responses while idle
    apb_read(8'h01, d, e);
    chk("idle_status", {e, d}, {1'b0, 8'h02});
    apb_write(8'h01, 8'hFF, e);
    chk("wr_status_err", e, 1);
    apb_write(8'h80, 8'hFF, e);
    chk("wr_shadow_err", e, 1);
    apb_write(8'h40, 8'hFF, e);
    chk("wr_unmapped_err", e, 1);
    apb_read(8'h40, d, e);
    chk("rd_unmapped", {e, d}, {1'b1, 8'h00});
    apb_read(8'h80, d, e);
    chk("sh00_after_wr", {e, d}, {1'b0, fuse_mem[7:0]});
    apb_read(8'h00, d, e);
    chk("rd_ctrl", {e, d}, {1'b0, 8'h00});

    // Reset in the middle of a load, then auto-reload with the reset strobe width
    apb_write(8'h02, 8'h02, e);
    rand_fuse();
    clr_stats();
    apb_write(8'h00, 8'h01, e);
    c0 = cyc;
    wait_addr(512, c0, 5000);
    chk("pre_rst_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("midrst_outs", {efuse_csb, efuse_strobe, busy, load_done}, 4'b1000);
    chk("midrst_addr", efuse_addr, 0);
    acc = '0;
    for (int n = 0; n < 64; n++) begin
      apb_read(8'(8'h80 + n), d, e);
      acc |= d;
    end
    chk("midrst_shadow_clear", acc, 0);
    apb_read(8'h02, d, e);
    chk("midrst_strb_default", {e, d}, {1'b0, 8'h04});
    clr_stats();
    rstn = 1'b1;
    tick();
    c0 = cyc;
    chk("reload_busy", busy, 1);
    wait_done(c0, 7000, lat);
    chk("reload_latency", lat, N * (4 + 2) + 1);
    chk("reload_strobe_cycles", strb_cycles, N * 4);
    chk("reload_addr_seq", addr_err, 0);
    check_shadow("reload");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
